// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: accepts one word read or write at a time,
// completes it LATENCY cycles later with a Done pulse, and holds Stall meanwhile.
module mem_responder #(
    parameter int unsigned LATENCY = 4,  // 1..15
    parameter int unsigned AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam int unsigned DEPTH   = 2 ** AW;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            op_wr_q;
    logic [AW-1:0]   idx_q;
    logic [15:0]     wdata_q;
    logic [15:0]     dout_q;
    logic            done_q;
    logic            stall_q;
    logic            err_q;
    logic [15:0]     mem_q [DEPTH];

    logic            req_valid;
    logic            req_bad;
    logic            take_req;
    logic            access_now;
    logic            acc_wr;
    logic [AW-1:0]   acc_idx;
    logic [15:0]     acc_data;
    logic [15:0]     rd_word;
    logic            unused_addr_hi;

    // Address bits above the word index only alias; they never select anything.
    assign unused_addr_hi = |Addr[15:AW+1];

    // A request is word-aligned and asks for exactly one of read or write.
    assign req_valid = (Rd ^ Wr) && !Addr[0];
    assign req_bad   = (Rd && Wr) || ((Rd || Wr) && Addr[0]);
    assign take_req  = (state_q != BUSY) && req_valid;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        acc_wr     = op_wr_q;
        acc_idx    = idx_q;
        acc_data   = wdata_q;
        access_now = 1'b0;
        if (state_q == BUSY) begin
            access_now = (cnt_q == 4'd1);
        end else if (take_req && (CNT_LOAD == 4'd0)) begin
            // Single-cycle latency: the access happens on the accepting edge.
            acc_wr     = Wr;
            acc_idx    = Addr[AW:1];
            acc_data   = DataIn;
            access_now = 1'b1;
        end
    end

    assign rd_word = mem_q[acc_idx];

    // cnt_q holds the edges left until the access; the access is performed on
    // the edge that takes it to zero, so BUSY lasts LATENCY-1 cycles.
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            dout_q  <= 16'h0000;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dout_q  <= 16'h0000;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        if (!op_wr_q) begin
                            dout_q <= rd_word;
                        end
                    end else begin
                        stall_q <= 1'b1;
                    end
                end
                default: begin
                    if (take_req) begin
                        op_wr_q <= Wr;
                        idx_q   <= Addr[AW:1];
                        wdata_q <= DataIn;
                        if (CNT_LOAD == 4'd0) begin
                            state_q <= DONE;
                            cnt_q   <= 4'd0;
                            done_q  <= 1'b1;
                            if (!Wr) begin
                                dout_q <= rd_word;
                            end
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_LOAD;
                            stall_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        err_q   <= req_bad;
                    end
                end
            endcase
        end
    end

    // NOTE: the array is cleared by reset, which forces it into flops; a RAM
    // macro could not honour the clear-on-reset behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (access_now && acc_wr) begin
            mem_q[acc_idx] <= acc_data;
        end
    end

    assign DataOut = dout_q;
    assign Done    = done_q;
    assign Stall   = stall_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (LATENCY 4 and 1) driven by
// directed and random requests, checked against a word-array reference model.
module tb_mem_responder;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic              clk = 1'b0;
    int                cyc = 0;
    logic [1:0]        rst_s = 2'b11;
    logic [1:0]        rd_s = 2'b00;
    logic [1:0]        wr_s = 2'b00;
    logic [1:0][15:0]  addr_s = '0;
    logic [1:0][15:0]  din_s = '0;
    logic [1:0][15:0]  dout_s;
    logic [1:0]        done_s;
    logic [1:0]        stall_s;
    logic [1:0]        err_s;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] model [2][256];
    int          st_lo [2] = '{1, 1};
    int          st_hi [2] = '{0, 0};
    int          errors = 0;
    int          checks = 0;

    mem_responder #(.LATENCY(LAT_A), .AW(8)) dut_a (
        .clk(clk), .rst(rst_s[0]), .Addr(addr_s[0]), .DataIn(din_s[0]),
        .Rd(rd_s[0]), .Wr(wr_s[0]), .DataOut(dout_s[0]), .Done(done_s[0]),
        .Stall(stall_s[0]), .Err(err_s[0])
    );

    mem_responder #(.LATENCY(LAT_B), .AW(8)) dut_b (
        .clk(clk), .rst(rst_s[1]), .Addr(addr_s[1]), .DataIn(din_s[1]),
        .Rd(rd_s[1]), .Wr(wr_s[1]), .DataOut(dout_s[1]), .Done(done_s[1]),
        .Stall(stall_s[1]), .Err(err_s[1])
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic qpop(input int d, output exp_t e);
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
    endtask

    function automatic int qdue(input int d);
        return (d == 0) ? q0[0].due : q1[0].due;
    endfunction

    // Monitor: per-cycle output checks plus scoreboard pops on Done/Err.
    task automatic mon(input int d);
        exp_t e;
        bit   exp_stall;
        exp_stall = (cyc >= st_lo[d]) && (cyc <= st_hi[d]);
        check($sformatf("stall_d%0d", d), 32'(stall_s[d]), 32'(exp_stall));
        check($sformatf("done_err_excl_d%0d", d), 32'(done_s[d] & err_s[d]), 32'd0);
        if (!done_s[d])
            check($sformatf("dout_idle_d%0d", d), 32'(dout_s[d]), 32'd0);
        if (done_s[d] || err_s[d]) begin
            if (qsize(d) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_d%0d: done=%0b err=%0b, none pending (cycle %0d)",
                         d, done_s[d], err_s[d], cyc);
            end else begin
                qpop(d, e);
                check($sformatf("kind_err_d%0d", d), 32'(err_s[d]), 32'(e.is_err));
                check($sformatf("resp_cycle_d%0d", d), 32'(cyc), 32'(e.due));
                if (done_s[d])
                    check($sformatf("dout_d%0d", d), 32'(dout_s[d]), 32'(e.data));
            end
        end else if (qsize(d) != 0 && qdue(d) <= cyc) begin
            qpop(d, e);
            checks++;
            errors++;
            $display("FAIL missing_resp_d%0d: no output, want %s at cycle %0d (now %0d)",
                     d, e.is_err ? "Err" : "Done", e.due, cyc);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic drive(input int d, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [15:0] di);
        rd_s[d]   = rd;
        wr_s[d]   = wr;
        addr_s[d] = a;
        din_s[d]  = di;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset(input int d);
        for (int i = 0; i < 256; i++) model[d][i] = 16'h0000;
        if (d == 0) q0.delete();
        else q1.delete();
        st_lo[d] = 1;
        st_hi[d] = 0;
    endtask

    // Present a request, let it be sampled, and record what the spec promises.
    task automatic start_req(input int d, input bit rd, input bit wr,
                             input logic [15:0] a, input logic [15:0] di, output bit valid);
        exp_t        e;
        int          n;
        logic [7:0]  idx;
        drive(d, rd, wr, a, di);
        @(posedge clk);
        #1;
        n = cyc;
        drive(d, 1'b0, 1'b0, 16'h0000, 16'h0000);
        valid = (rd ^ wr) && !a[0];
        idx   = a[8:1];
        if (valid) begin
            if (wr) model[d][idx] = di;
            e.is_err = 1'b0;
            e.data   = wr ? 16'h0000 : model[d][idx];
            e.due    = n + lat(d) - 1;
            qpush(d, e);
            st_lo[d] = n;
            st_hi[d] = n + lat(d) - 2;
        end else if (rd || wr) begin
            e.is_err = 1'b1;
            e.data   = 16'h0000;
            e.due    = n;
            qpush(d, e);
        end
    endtask

    // Full request; returns in the DONE cycle so the next one is back-to-back.
    task automatic req(input int d, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [15:0] di, input bit noise);
        bit v;
        start_req(d, rd, wr, a, di, v);
        if (v) begin
            for (int k = 0; k < lat(d) - 1; k++) begin
                if (noise)
                    drive(d, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
                @(posedge clk);
                #1;
            end
            drive(d, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
    endtask

    task automatic run_dut(input int d);
        bit          v;
        int          r;
        logic [15:0] a;
        req(d, 1, 0, 16'h0010, 16'h0000, 0);
        req(d, 0, 1, 16'h0020, 16'hBEEF, 0);
        req(d, 1, 0, 16'h0020, 16'h0000, 0);
        gap(1);
        req(d, 0, 1, 16'h0004, 16'h1111, 0);
        gap(1);
        req(d, 1, 1, 16'h0004, 16'hDEAD, 0);
        gap(1);
        req(d, 1, 0, 16'h0003, 16'h0000, 0);
        gap(1);
        req(d, 0, 1, 16'h0005, 16'h9999, 0);
        gap(1);
        req(d, 1, 0, 16'h0004, 16'h0000, 0);
        req(d, 0, 1, 16'h0002, 16'h1234, 0);
        req(d, 1, 0, 16'h0202, 16'h0000, 0);
        req(d, 0, 1, 16'h01FE, 16'h5555, 0);
        req(d, 1, 0, 16'h01FE, 16'h0000, 0);
        req(d, 0, 1, 16'h0040, 16'hAAAA, 1);
        gap(2);
        req(d, 1, 0, 16'h0040, 16'h0000, 0);

        // Asynchronous reset in the cycle after the write is accepted.
        start_req(d, 0, 1, 16'h0008, 16'h7777, v);
        #1 rst_s[d] = 1'b0;
        #1;
        model_reset(d);
        check($sformatf("arst_dout_d%0d", d), 32'(dout_s[d]), 32'd0);
        check($sformatf("arst_done_d%0d", d), 32'(done_s[d]), 32'd0);
        check($sformatf("arst_stall_d%0d", d), 32'(stall_s[d]), 32'd0);
        check($sformatf("arst_err_d%0d", d), 32'(err_s[d]), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_s[d] = 1'b1;
        req(d, 1, 0, 16'h0008, 16'h0000, 0);
        req(d, 1, 0, 16'h0020, 16'h0000, 0);
        gap(1);

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            a = 16'($urandom);
            a[8:1] = 8'($urandom_range(0, 15));
            a[0] = 1'b0;
            case (r)
                0, 1, 2, 3: req(d, 0, 1, a, 16'($urandom), 1'($urandom));
                4, 5, 6:    req(d, 1, 0, a, 16'h0000, 1'($urandom));
                7:          req(d, 1, 1, a, 16'($urandom), 0);
                8:          req(d, 1'($urandom), 1'($urandom), a | 16'h0001, 16'($urandom), 0);
                default:    gap($urandom_range(1, 3));
            endcase
        end
        gap(lat(d) + 3);
        check($sformatf("drained_d%0d", d), 32'(qsize(d)), 32'd0);
    endtask

    initial begin
        #1 rst_s = 2'b00;
        #2;
        model_reset(0);
        model_reset(1);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_dout_d%0d", d), 32'(dout_s[d]), 32'd0);
            check($sformatf("rst_done_d%0d", d), 32'(done_s[d]), 32'd0);
            check($sformatf("rst_stall_d%0d", d), 32'(stall_s[d]), 32'd0);
            check($sformatf("rst_err_d%0d", d), 32'(err_s[d]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_s = 2'b11;
        run_dut(0);
        run_dut(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
